gp_sum_pipe: RTL and testbench

//   Two-stage pipelined parallel-prefix adder that consumes bitwise and

---
 rtl/gp_sum_pipe.sv | 140 ++++++++++++++
 tb/tb_gp_sum_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gp_sum_pipe.sv
// Two-stage pipelined parallel-prefix adder: stage 1 resolves the low segment and registers its
// carry, stage 2 resolves the high segment against it. Valid/ready handshake on both sides.
module gp_sum_pipe #(
    parameter int unsigned WIDTH    = 22,
    parameter int unsigned LO_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned HI_WIDTH = WIDTH - LO_WIDTH;
    localparam int unsigned LO_N     = LO_WIDTH + 1;
    localparam int unsigned HI_N     = HI_WIDTH + 1;
    localparam int unsigned LO_LVL   = $clog2(LO_N);
    localparam int unsigned HI_LVL   = $clog2(HI_N);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;

    assign p = a ^ b;
    assign g = a & b;

    // Low-segment Kogge-Stone; entry 0 carries cin so entry k ends as the carry into bit k.
    logic [LO_N-1:0] lo_gv;
    logic [LO_N-1:0] lo_pv;
    logic [LO_N-1:0] lo_gn;
    logic [LO_N-1:0] lo_pn;

    always_comb begin
        lo_gv = {g[LO_WIDTH-1:0], cin};
        lo_pv = {p[LO_WIDTH-1:0], 1'b0};
        lo_gn = lo_gv;
        lo_pn = lo_pv;
        for (int l = 0; l < LO_LVL; l++) begin
            lo_gn = lo_gv;
            lo_pn = lo_pv;
            for (int k = 0; k < LO_N; k++) begin
                if (k >= (1 << l)) begin
                    lo_gn[k] = lo_gv[k] | (lo_pv[k] & lo_gv[(k >= (1 << l)) ? k - (1 << l) : 0]);
                    lo_pn[k] = lo_pv[k] & lo_pv[(k >= (1 << l)) ? k - (1 << l) : 0];
                end
            end
            lo_gv = lo_gn;
            lo_pv = lo_pn;
        end
    end

    logic [LO_WIDTH-1:0] lo_sum;
    logic                lo_c;

    assign lo_sum = p[LO_WIDTH-1:0] ^ lo_gv[LO_WIDTH-1:0];
    assign lo_c   = lo_gv[LO_WIDTH];

    logic                s1_valid;
    logic [LO_WIDTH-1:0] s1_lo_sum;
    logic                s1_c;
    logic [HI_WIDTH-1:0] s1_p;
    logic [HI_WIDTH-1:0] s1_g;
    logic                s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_lo_sum <= '0;
            s1_c      <= 1'b0;
            s1_p      <= '0;
            s1_g      <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_lo_sum <= lo_sum;
                s1_c      <= lo_c;
                s1_p      <= p[WIDTH-1:LO_WIDTH];
                s1_g      <= g[WIDTH-1:LO_WIDTH];
            end
        end
    end

    // High-segment prefix tree seeded with the registered low-segment carry.
    logic [HI_N-1:0] hi_gv;
    logic [HI_N-1:0] hi_pv;
    logic [HI_N-1:0] hi_gn;
    logic [HI_N-1:0] hi_pn;

    always_comb begin
        hi_gv = {s1_g, s1_c};
        hi_pv = {s1_p, 1'b0};
        hi_gn = hi_gv;
        hi_pn = hi_pv;
        for (int l = 0; l < HI_LVL; l++) begin
            hi_gn = hi_gv;
            hi_pn = hi_pv;
            for (int k = 0; k < HI_N; k++) begin
                if (k >= (1 << l)) begin
                    hi_gn[k] = hi_gv[k] | (hi_pv[k] & hi_gv[(k >= (1 << l)) ? k - (1 << l) : 0]);
                    hi_pn[k] = hi_pv[k] & hi_pv[(k >= (1 << l)) ? k - (1 << l) : 0];
                end
            end
            hi_gv = hi_gn;
            hi_pv = hi_pn;
        end
    end

    logic [HI_WIDTH-1:0] hi_sum;
    logic                hi_cout;
    logic                hi_ovf;

    assign hi_sum  = s1_p ^ hi_gv[HI_WIDTH-1:0];
    assign hi_cout = hi_gv[HI_WIDTH];
    assign hi_ovf  = hi_gv[HI_WIDTH-1] ^ hi_gv[HI_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= {hi_sum, s1_lo_sum};
                cout <= hi_cout;
                ovf  <= hi_ovf;
            end
        end
    end

endmodule

// File: tb/tb_gp_sum_pipe.sv
// Self-checking bench for gp_sum_pipe: directed corner cases, backpressure, reset, and random
// streaming against an arithmetic reference model with an in-order scoreboard.
module tb_gp_sum_pipe;
    localparam int W = 22;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    logic [W+1:0] exp_q[$];
    logic         hold_pending = 1'b0;
    logic [W+1:0] hold_val;

    always #5 clk = ~clk;

    gp_sum_pipe #(
        .WIDTH   (W),
        .LO_WIDTH(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    // Reference result packed as {cout, ovf, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
        logic [W:0]   full;
        logic [W-1:0] s;
        logic         ov;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        s    = full[W-1:0];
        ov   = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        return {full[W], ov, s};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci);
        in_valid = v;
        a        = x;
        b        = y;
        cin      = ci;
        #1;
    endtask

    // One clock cycle with scoreboard bookkeeping for whatever handshakes happen in it.
    task automatic cycle();
        logic acc;
        logic drn;
        logic [W+1:0] e;
        #1;
        acc = in_valid && in_ready && !rst;
        drn = out_valid && out_ready && !rst;
        if (!rst && hold_pending) begin
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_data", {8'b0, cout, ovf, sum}, {8'b0, hold_val});
        end
        if (drn) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", {31'b0, out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", {8'b0, cout, ovf, sum}, {8'b0, e});
                n_out++;
            end
        end
        hold_pending = !rst && out_valid && !out_ready;
        hold_val     = {cout, ovf, sum};
        if (acc) exp_q.push_back(model(a, b, cin));
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            hold_pending = 1'b0;
        end
    endtask

    // Single transaction on an empty pipe; result must appear exactly two cycles after accept.
    task automatic directed(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ci, input logic [W+1:0] exp);
        out_ready = 1'b1;
        drive(1'b1, x, y, ci);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        cycle();
        drive(1'b0, '0, '0, 1'b0);
        check({tag, "_lat1_valid"}, {31'b0, out_valid}, 32'd0);
        cycle();
        check({tag, "_lat2_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_data"}, {8'b0, cout, ovf, sum}, {8'b0, exp});
        cycle();
        check({tag, "_drained"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0]  r;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           n_acc;
        int           start_out;
        int           budget;

        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_sum", {8'b0, cout, ovf, sum}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        directed("seg_carry", 22'h00FFFF, 22'h000001, 1'b0, {1'b0, 1'b0, 22'h010000});
        directed("wrap", 22'h3FFFFF, 22'h000000, 1'b1, {1'b1, 1'b0, 22'h000000});
        directed("ovf_pos", 22'h1FFFFF, 22'h000001, 1'b0, {1'b0, 1'b1, 22'h200000});
        directed("ovf_neg", 22'h200000, 22'h200000, 1'b0, {1'b1, 1'b1, 22'h000000});

        // Backpressure: two accepted, third offer refused until downstream drains.
        out_ready = 1'b0;
        drive(1'b1, 22'd1, 22'd1, 1'b0);
        check("bp_acc1", {31'b0, in_ready}, 32'd1);
        cycle();
        drive(1'b1, 22'd2, 22'd2, 1'b0);
        check("bp_acc2", {31'b0, in_ready}, 32'd1);
        cycle();
        drive(1'b1, 22'd3, 22'd3, 1'b0);
        check("bp_full_ready", {31'b0, in_ready}, 32'd0);
        check("bp_full_valid", {31'b0, out_valid}, 32'd1);
        check("bp_full_sum", {10'b0, sum}, 32'd2);
        cycle();
        check("bp_hold_ready", {31'b0, in_ready}, 32'd0);
        check("bp_hold_sum", {10'b0, sum}, 32'd2);
        cycle();
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'b0, in_ready}, 32'd1);
        check("bp_out0", {10'b0, sum}, 32'd2);
        cycle();
        drive(1'b0, '0, '0, 1'b0);
        check("bp_out1_valid", {31'b0, out_valid}, 32'd1);
        check("bp_out1", {10'b0, sum}, 32'd4);
        cycle();
        check("bp_out2_valid", {31'b0, out_valid}, 32'd1);
        check("bp_out2", {10'b0, sum}, 32'd6);
        cycle();
        check("bp_empty", {31'b0, out_valid}, 32'd0);

        // Full-rate streaming: no bubbles on either side.
        start_out = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            r  = $urandom;
            ra = r[W-1:0];
            r  = $urandom;
            rb = r[W-1:0];
            drive(1'b1, ra, rb, r[31]);
            check("stream_in_ready", {31'b0, in_ready}, 32'd1);
            if (i >= 2) check("stream_no_bubble", {31'b0, out_valid}, 32'd1);
            cycle();
        end
        drive(1'b0, '0, '0, 1'b0);
        check("stream_tail0", {31'b0, out_valid}, 32'd1);
        cycle();
        check("stream_tail1", {31'b0, out_valid}, 32'd1);
        cycle();
        check("stream_count", n_out - start_out, 32'd100);

        // Random valid and out_ready: ordering and holding under stalls.
        start_out = n_out;
        n_acc     = 0;
        budget    = 0;
        while (n_acc < 100 && budget < 3000) begin
            r         = $urandom;
            out_ready = r[0];
            ra        = r[W:1];
            r         = $urandom;
            rb        = r[W-1:0];
            drive(r[30:29] != 2'b00, ra, rb, r[31]);
            if (in_valid && in_ready) n_acc++;
            cycle();
            budget++;
        end
        check("rand_accept_budget", n_acc, 32'd100);
        drive(1'b0, '0, '0, 1'b0);
        out_ready = 1'b1;
        budget    = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            cycle();
            budget++;
        end
        check("rand_drain_queue", exp_q.size(), 32'd0);
        check("rand_count", n_out - start_out, 32'd100);

        // Reset with both stages occupied.
        out_ready = 1'b0;
        drive(1'b1, 22'h123456, 22'h0ABCDE, 1'b1);
        cycle();
        drive(1'b1, 22'h3F0F0F, 22'h00F0F0, 1'b0);
        cycle();
        check("mid_full_ready", {31'b0, in_ready}, 32'd0);
        check("mid_full_valid", {31'b0, out_valid}, 32'd1);
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        cycle();
        rst = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_data", {8'b0, cout, ovf, sum}, 32'd0);
        check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        r  = $urandom;
        ra = r[W-1:0];
        r  = $urandom;
        rb = r[W-1:0];
        directed("post_rst", ra, rb, r[31], model(ra, rb, r[31]));
        check("final_queue", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
